// File: rtl/up5bit_counter_arbiter.sv
// up5bit_counter_arbiter: round-robin sequencer that lends one WIDTH-bit up
// counter to one of two requesters at a time. The winner counts 0..limit,
// then a one-cycle done pulse frees the counter; withdrawing req mid-run
// gives a one-cycle abort pulse instead.
// Optional feature macro: COUNTER_PAUSE_EN adds a pause input that freezes
// the count (and the limit compare) while the counter is running.
module up5bit_counter_arbiter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
`ifdef COUNTER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q,   lim_d;
  logic             owner_q, owner_d;
  logic             last_q,  last_d;
  logic             abort_q, abort_d;
  logic             winner;
  logic             hold;

`ifdef COUNTER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // State and datapath registers; last winner starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
      lim_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

  // Arbitration, counting and run termination (abort beats limit match).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    lim_d   = lim_q;
    owner_d = owner_q;
    last_d  = last_q;
    abort_d = 1'b0;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (req != 2'b00) begin
          if (req == 2'b11) winner = ~last_q;
          else              winner = req[1];
          owner_d = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          lim_d   = winner ? limit1 : limit0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          abort_d = 1'b1;
          last_d  = owner_q;
          grant_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (hold) begin
          count_d = count_q;
        end else if (count_q == lim_q) begin
          grant_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      DONE: begin
        last_d  = owner_q;
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign grant   = grant_q;
  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign done_id = (state_q == DONE) & owner_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_up5bit_counter_arbiter.sv
// Scoreboard bench for up5bit_counter_arbiter: a stimulus process drives
// inputs on the falling edge and pushes the reference model's expected
// outputs; a monitor pops and compares just after each rising edge.
module tb_up5bit_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [4:0] limit0 = '0;
  logic [4:0] limit1 = '0;
  logic       pause = 1'b0;
  logic [1:0] grant;
  logic [4:0] count;
  logic       busy, done, done_id, abort;

`ifdef COUNTER_PAUSE_EN
  localparam bit PAUSE_BUILT = 1'b1;
`else
  localparam bit PAUSE_BUILT = 1'b0;
`endif

  up5bit_counter_arbiter #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .req(req), .limit0(limit0), .limit1(limit1),
`ifdef COUNTER_PAUSE_EN
    .pause(pause),
`endif
    .grant(grant), .count(count), .busy(busy), .done(done),
    .done_id(done_id), .abort(abort)
  );

  always #5 clk = ~clk;

  // Expected output vector {grant, count, busy, done, done_id, abort}.
  logic [10:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: owner -1 means the counter is free.
  int m_owner = -1;
  int m_cnt = 0;
  int m_lim = 0;
  int m_last = 1;
  bit m_done = 0;
  int m_done_id = 0;
  bit m_abort = 0;

  task automatic model_edge(input bit rst, input logic [1:0] rq,
                            input int l0, input int l1, input bit ps);
    bit paused;
    paused = ps & PAUSE_BUILT;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_lim = 0; m_last = 1;
      m_done = 0; m_done_id = 0; m_abort = 0;
    end else if (m_done) begin
      m_last = m_done_id;
      m_done = 0; m_done_id = 0; m_cnt = 0; m_abort = 0;
    end else if (m_owner < 0) begin
      m_abort = 0;
      m_cnt = 0;
      if (rq != 2'b00) begin
        if (rq == 2'b11) m_owner = 1 - m_last;
        else             m_owner = rq[0] ? 0 : 1;
        m_lim = (m_owner == 1) ? l1 : l0;
      end
    end else begin
      m_abort = 0;
      if (rq[m_owner] == 1'b0) begin
        m_abort = 1; m_last = m_owner; m_owner = -1; m_cnt = 0;
      end else if (paused) begin
        m_cnt = m_cnt;
      end else if (m_cnt == m_lim) begin
        m_done = 1; m_done_id = m_owner; m_owner = -1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] g;
    logic [4:0] c;
    g = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    c = m_cnt[4:0];
    return {g, c, (m_owner >= 0), m_done, (m_done && m_done_id == 1), m_abort};
  endfunction

  task automatic step(input bit rst, input logic [1:0] rq,
                      input int l0, input int l1, input bit ps);
    @(negedge clk);
    reset = rst; req = rq; limit0 = l0[4:0]; limit1 = l1[4:0]; pause = ps;
    model_edge(rst, rq, l0, l1, ps);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation.
  initial begin
    logic [10:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {grant, count, busy, done, done_id, abort};
        checks++;
        if (g === e) passed++;
        else $display("FAIL outputs t=%0t got grant=%b count=%0d busy=%b done=%b id=%b abort=%b exp grant=%b count=%0d busy=%b done=%b id=%b abort=%b",
                      $time, g[10:9], g[8:4], g[3], g[2], g[1], g[0],
                      e[10:9], e[8:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    bit r0, r1;
    int l0, l1, n;
    // Reset held with both requesters active.
    repeat (3) step(1, 2'b11, 5, 5, 0);
    // Single requester 0, limit 4, drop after done.
    n = 0;
    do begin step(0, 2'b01, 4, 9, 0); n++; end while (!m_done && n < 20);
    step(0, 2'b00, 4, 9, 0);
    step(0, 2'b00, 4, 9, 0);
    // Both held: alternating grants.
    repeat (30) step(0, 2'b11, 2, 3, 0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    // Requester 1 at all-ones limit; limit changes mid-run are ignored.
    n = 0;
    do begin step(0, 2'b10, 7, (n == 0) ? 31 : 3, 0); n++; end while (!m_done && n < 40);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    // Withdraw at count 5.
    n = 0;
    do begin step(0, 2'b01, 10, 0, 0); n++; end while (!(m_owner == 0 && m_cnt == 5) && n < 20);
    step(0, 2'b00, 10, 0, 0);
    step(0, 2'b00, 10, 0, 0);
    // Reset at count 5.
    n = 0;
    do begin step(0, 2'b01, 10, 0, 0); n++; end while (!(m_owner == 0 && m_cnt == 5) && n < 20);
    step(1, 2'b01, 10, 0, 0);
    step(0, 2'b00, 10, 0, 0);
    // Pause for 3 cycles at count 2 (no effect when the feature is absent).
    n = 0;
    do begin step(0, 2'b01, 4, 0, 0); n++; end while (!(m_owner == 0 && m_cnt == 2) && n < 20);
    repeat (3) step(0, 2'b01, 4, 0, 1);
    n = 0;
    do begin step(0, 2'b01, 4, 0, 0); n++; end while (!m_done && n < 20);
    step(0, 2'b00, 0, 0, 1);
    // Randomized traffic.
    r0 = 0; r1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!r0) r0 = ($urandom_range(0, 3) == 0);
      else if (m_done && m_done_id == 0) r0 = $urandom_range(0, 1);
      else if (m_owner == 0 && $urandom_range(0, 39) == 0) r0 = 0;
      if (!r1) r1 = ($urandom_range(0, 3) == 0);
      else if (m_done && m_done_id == 1) r1 = $urandom_range(0, 1);
      else if (m_owner == 1 && $urandom_range(0, 39) == 0) r1 = 0;
      l0 = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 6);
      l1 = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 6);
      step(($urandom_range(0, 199) == 0), {r1, r0}, l0, l1, ($urandom_range(0, 7) == 0));
    end
    // Let the monitor drain the scoreboard, bounded.
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
